// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, sprite beat type and scheduler states.
package sprite_pkg;
   localparam int CANVAS_WIDTH  = 360;
   localparam int CANVAS_HEIGHT = 720;
   localparam int NUM_FRAMES    = 5;
   localparam int X_W = $clog2(CANVAS_WIDTH);
   localparam int Y_W = $clog2(CANVAS_HEIGHT);
   localparam int F_W = $clog2(NUM_FRAMES);

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [F_W-1:0] frame;
   } sprite_t;

   typedef enum logic [1:0] {WAIT_FRAME, GAME, CURSOR, DONE} sched_state_t;
endpackage

// File: rtl/sprite_fifo.sv
// sprite_fifo: synchronous FIFO of sprite beats with flush; DEPTH must be a power of 2.
module sprite_fifo
   import sprite_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic    clk_pixel_in,
   input  logic    rst_n_in,
   input  logic    push,
   input  logic    pop,
   input  logic    flush,
   input  sprite_t data,
   output logic    full,
   output logic    empty,
   output sprite_t head
);
   localparam int AW = $clog2(DEPTH);

   sprite_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic do_push, do_pop;

   always_comb begin
      full    = count == (AW+1)'(DEPTH);
      empty   = count == '0;
      head    = mem[rd_ptr];
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   always_ff @(posedge clk_pixel_in)
      if (do_push) mem[wr_ptr] <= data;

   always_ff @(posedge clk_pixel_in or negedge rst_n_in)
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: per-frame sprite sequencer; issues buffered processor sprites in order
// and appends the latched mouse cursor as the final beat of each frame.
module sprite_scheduler
   import sprite_pkg::*;
#(
   parameter int MAX_SPRITES  = 64,
   parameter int FIFO_DEPTH   = 8,
   parameter int CURSOR_FRAME = 0
) (
   input  logic                              clk_pixel_in,
   input  logic                              rst_n_in,
   input  logic                              new_frame_in,
   input  logic                              proc_valid_in,
   output logic                              proc_ready_out,
   input  logic [X_W-1:0]                    proc_x_in,
   input  logic [Y_W-1:0]                    proc_y_in,
   input  logic [F_W-1:0]                    proc_frame_in,
   input  logic                              proc_last_in,
   input  logic                              cursor_en_in,
   input  logic [X_W-1:0]                    cursor_x_in,
   input  logic [Y_W-1:0]                    cursor_y_in,
   output logic                              spr_valid_out,
   input  logic                              spr_ready_in,
   output logic [X_W-1:0]                    spr_x_out,
   output logic [Y_W-1:0]                    spr_y_out,
   output logic [F_W-1:0]                    spr_frame_out,
   output logic                              spr_is_cursor_out,
   output logic                              overrun_out,
   output logic [7:0]                        drop_count_out,
   output logic [$clog2(MAX_SPRITES+2)-1:0]  issue_count_out
);
   localparam int AW = $clog2(MAX_SPRITES + 1);
   localparam int IW = $clog2(MAX_SPRITES + 2);

   sched_state_t state, state_nx;
   sprite_t in_spr, fifo_head, out_spr, cursor_spr;
   logic full, empty, push, pop, in_hs, out_hs, room, game_done, load_cursor, overrun;
   logic cur_en, seen_last, out_cursor;
   logic [X_W-1:0] cur_x;
   logic [Y_W-1:0] cur_y;
   logic [AW-1:0] acc_cnt;

   sprite_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_pixel_in(clk_pixel_in),
      .rst_n_in    (rst_n_in),
      .push        (push),
      .pop         (pop),
      .flush       (new_frame_in),
      .data        (in_spr),
      .full        (full),
      .empty       (empty),
      .head        (fifo_head)
   );

   always_ff @(posedge clk_pixel_in or negedge rst_n_in)
      if (!rst_n_in) state <= WAIT_FRAME;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      if (new_frame_in) state_nx = GAME;
      else if (game_done) state_nx = cur_en ? CURSOR : DONE;
      else if (state == CURSOR && spr_ready_in) state_nx = DONE;
   end

   // ready is withheld during new_frame so no handshaken beat is lost to the flush
   always_comb begin
      proc_ready_out = state == GAME && !full && !seen_last && !new_frame_in;
      in_hs       = proc_valid_in && proc_ready_out;
      room        = acc_cnt < AW'(MAX_SPRITES);
      push        = in_hs && room;
      out_hs      = spr_valid_out && spr_ready_in;
      pop         = state == GAME && !empty && (!spr_valid_out || spr_ready_in) && !new_frame_in;
      game_done   = state == GAME && seen_last && empty && !spr_valid_out;
      load_cursor = game_done && cur_en;
      overrun     = new_frame_in && (state == GAME || state == CURSOR) &&
                    (!empty || spr_valid_out || cur_en);
      in_spr      = '{x: proc_x_in, y: proc_y_in, frame: proc_frame_in};
      cursor_spr  = '{x: cur_x, y: cur_y, frame: F_W'(CURSOR_FRAME)};
   end

   always_ff @(posedge clk_pixel_in or negedge rst_n_in)
      if (!rst_n_in) begin
         spr_valid_out <= 1'b0;
         out_cursor    <= 1'b0;
         out_spr       <= '0;
      end else if (new_frame_in) begin
         spr_valid_out <= 1'b0;
         out_cursor    <= 1'b0;
      end else if (state == GAME && (!spr_valid_out || spr_ready_in)) begin
         spr_valid_out <= !empty || load_cursor;
         out_cursor    <= load_cursor;
         out_spr       <= empty ? cursor_spr : fifo_head;
      end else if (state == CURSOR && spr_ready_in) begin
         spr_valid_out <= 1'b0;
         out_cursor    <= 1'b0;
      end

   always_ff @(posedge clk_pixel_in or negedge rst_n_in)
      if (!rst_n_in) begin
         cur_x           <= '0;
         cur_y           <= '0;
         cur_en          <= 1'b0;
         seen_last       <= 1'b0;
         acc_cnt         <= '0;
         drop_count_out  <= '0;
         issue_count_out <= '0;
         overrun_out     <= 1'b0;
      end else if (new_frame_in) begin
         cur_x           <= cursor_x_in;
         cur_y           <= cursor_y_in;
         cur_en          <= cursor_en_in;
         seen_last       <= 1'b0;
         acc_cnt         <= '0;
         drop_count_out  <= '0;
         issue_count_out <= '0;
         overrun_out     <= overrun;
      end else begin
         overrun_out <= 1'b0;
         if (in_hs && proc_last_in) seen_last <= 1'b1;
         if (push) acc_cnt <= acc_cnt + AW'(1);
         if (in_hs && !room && drop_count_out != 8'hff) drop_count_out <= drop_count_out + 8'd1;
         if (out_hs) issue_count_out <= issue_count_out + IW'(1);
      end

   assign spr_x_out         = out_spr.x;
   assign spr_y_out         = out_spr.y;
   assign spr_frame_out     = out_spr.frame;
   assign spr_is_cursor_out = out_cursor;
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: directed frames against the default scheduler and a
// MAX_SPRITES=4 copy sharing the same stimulus.
module tb_sprite_scheduler;
   import sprite_pkg::*;

   logic clk, rst_n, new_frame, proc_valid, proc_last, cursor_en, spr_ready;
   logic [8:0] proc_x, cursor_x;
   logic [9:0] proc_y, cursor_y;
   logic [2:0] proc_frame;
   logic rdy0, v0, c0, ovr0, rdy_b, vb, cb, ovrb;
   logic [8:0] x0, xb;
   logic [9:0] y0, yb;
   logic [2:0] f0, fb;
   logic [7:0] drop0, dropb;
   logic [6:0] iss0;
   logic [2:0] issb;
   logic [22:0] beat0, beatb, held0;
   logic [22:0] q0 [$];
   logic [22:0] q1 [$];
   logic stall0;
   int checks = 0, errors = 0, hold_err = 0, cur_cnt = 0;
   int base, cb0, w, ws, n;

   sprite_scheduler dut (
      .clk_pixel_in(clk), .rst_n_in(rst_n), .new_frame_in(new_frame),
      .proc_valid_in(proc_valid), .proc_ready_out(rdy0), .proc_x_in(proc_x),
      .proc_y_in(proc_y), .proc_frame_in(proc_frame), .proc_last_in(proc_last),
      .cursor_en_in(cursor_en), .cursor_x_in(cursor_x), .cursor_y_in(cursor_y),
      .spr_valid_out(v0), .spr_ready_in(spr_ready), .spr_x_out(x0), .spr_y_out(y0),
      .spr_frame_out(f0), .spr_is_cursor_out(c0), .overrun_out(ovr0),
      .drop_count_out(drop0), .issue_count_out(iss0)
   );

   sprite_scheduler #(.MAX_SPRITES(4)) dut_b (
      .clk_pixel_in(clk), .rst_n_in(rst_n), .new_frame_in(new_frame),
      .proc_valid_in(proc_valid), .proc_ready_out(rdy_b), .proc_x_in(proc_x),
      .proc_y_in(proc_y), .proc_frame_in(proc_frame), .proc_last_in(proc_last),
      .cursor_en_in(cursor_en), .cursor_x_in(cursor_x), .cursor_y_in(cursor_y),
      .spr_valid_out(vb), .spr_ready_in(spr_ready), .spr_x_out(xb), .spr_y_out(yb),
      .spr_frame_out(fb), .spr_is_cursor_out(cb), .overrun_out(ovrb),
      .drop_count_out(dropb), .issue_count_out(issb)
   );

   assign beat0 = {c0, x0, y0, f0};
   assign beatb = {cb, xb, yb, fb};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // beat log and stall-stability watch; overrun is the one allowed withdrawal
   always @(negedge clk) begin
      if (!rst_n) stall0 = 1'b0;
      else begin
         if (stall0 && !ovr0 && (!v0 || beat0 != held0)) hold_err++;
         stall0 = v0 && !spr_ready;
         held0 = beat0;
         if (v0 && spr_ready) q0.push_back(beat0);
         if (vb && spr_ready) q1.push_back(beatb);
         if (v0 && c0) cur_cnt++;
      end
   end

   function automatic logic [22:0] bt(input int x, input int y, input int f, input int c);
      return {c[0], x[8:0], y[9:0], f[2:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input bit en, input int x, input int y);
      new_frame = 1'b1;
      cursor_en = en;
      cursor_x  = 9'(x);
      cursor_y  = 10'(y);
      tick();
      new_frame = 1'b0;
   endtask

   task automatic send(input bit sel, input int x, input int y, input int f, input bit last,
                       output int waited);
      proc_valid = 1'b1;
      proc_x     = 9'(x);
      proc_y     = 10'(y);
      proc_frame = 3'(f);
      proc_last  = last;
      waited     = 0;
      #1;
      while (!(sel ? rdy_b : rdy0) && waited < 40) begin
         @(posedge clk);
         #2;
         waited++;
      end
      if (waited >= 40) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      proc_valid = 1'b0;
      proc_last  = 1'b0;
   endtask

   task automatic wait_done(input bit sel, input string tag);
      int k = 0;
      while ((sel ? dut_b.state : dut.state) != DONE && k < 100) begin
         tick();
         k++;
      end
      check(tag, k < 100, 1);
   endtask

   initial begin
      rst_n = 1'b0; new_frame = 1'b0; proc_valid = 1'b0; proc_last = 1'b0;
      cursor_en = 1'b0; spr_ready = 1'b0; proc_x = '0; proc_y = '0; proc_frame = '0;
      cursor_x = '0; cursor_y = '0;
      repeat (3) tick();
      check("rst_outputs", {rdy0, v0, c0, ovr0, drop0, iss0}, 0);
      check("rst_outputs_b", {rdy_b, vb, cb, ovrb, dropb, issb, xb, yb, fb}, 0);
      rst_n = 1'b1;
      tick();

      // nominal frame
      base = q0.size();
      frame(1, 100, 200);
      check("nom_no_overrun", ovr0, 0);
      spr_ready = 1'b1;
      send(0, 10, 5, 1, 0, w);
      n = 0;
      while (!v0 && n < 4) begin tick(); n++; end
      check("nom_latency", n <= 1, 1);
      send(0, 20, 6, 2, 0, w);
      send(0, 30, 7, 3, 1, w);
      wait_done(0, "nom_done");
      check("nom_beats", q0.size() - base, 4);
      check("nom_b0", q0[base], bt(10, 5, 1, 0));
      check("nom_b1", q0[base+1], bt(20, 6, 2, 0));
      check("nom_b2", q0[base+2], bt(30, 7, 3, 0));
      check("nom_cursor", q0[base+3], bt(100, 200, 0, 1));
      check("nom_issue", iss0, 4);
      check("nom_ready_done", rdy0, 0);

      // backpressure: 9 accepted (8 in FIFO + output stage), 10th stalls
      base = q0.size();
      frame(1, 50, 60);
      check("bp_no_overrun", ovr0, 0);
      spr_ready = 1'b0;
      ws = 0;
      for (int i = 0; i < 9; i++) begin
         send(0, 40 + i, 300 + i, i % 5, 0, w);
         ws += w;
      end
      check("bp_no_stall9", ws, 0);
      proc_valid = 1'b1; proc_x = 9'd49; proc_y = 10'd309; proc_frame = 3'd4; proc_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_ready_full", rdy0, 0);
      end
      check("bp_held_beat", {v0, beat0}, {1'b1, bt(40, 300, 0, 0)});
      spr_ready = 1'b1;
      send(0, 49, 309, 4, 1, w);
      wait_done(0, "bp_done");
      check("bp_beats", q0.size() - base, 11);
      for (int i = 0; i < 10; i++) check("bp_order", q0[base+i], bt(40 + i, 300 + i, i % 5, 0));
      check("bp_cursor", q0[base+10], bt(50, 60, 0, 1));
      check("bp_issue", iss0, 11);
      check("bp_hold", hold_err, 0);

      // sprite budget on the MAX_SPRITES=4 copy
      base = q1.size();
      frame(1, 7, 8);
      ws = 0;
      for (int i = 0; i < 6; i++) begin
         send(1, 60 + i, 70 + i, i % 5, i == 5, w);
         ws += w;
      end
      check("bud_no_stall", ws, 0);
      wait_done(1, "bud_done");
      check("bud_beats", q1.size() - base, 5);
      for (int i = 0; i < 4; i++) check("bud_order", q1[base+i], bt(60 + i, 70 + i, i % 5, 0));
      check("bud_cursor", q1[base+4], bt(7, 8, 0, 1));
      check("bud_drop", dropb, 2);
      check("bud_issue", issb, 5);

      // overrun with three sprites queued and no last
      base = q0.size();
      frame(1, 11, 12);
      spr_ready = 1'b0;
      send(0, 1, 2, 3, 0, w);
      send(0, 4, 5, 1, 0, w);
      send(0, 6, 7, 2, 0, w);
      tick();
      check("ovr_pre_valid", v0, 1);
      frame(1, 222, 333);
      check("ovr_pulse", ovr0, 1);
      check("ovr_valid_drop", v0, 0);
      check("ovr_fifo_empty", dut.u_fifo.empty, 1);
      tick();
      check("ovr_one_cycle", ovr0, 0);
      spr_ready = 1'b1;
      send(0, 15, 16, 4, 1, w);
      wait_done(0, "ovr_done");
      check("ovr_beats", q0.size() - base, 2);
      check("ovr_b0", q0[base], bt(15, 16, 4, 0));
      check("ovr_new_cursor", q0[base+1], bt(222, 333, 0, 1));
      check("ovr_issue", iss0, 2);

      // asynchronous reset while a beat is held
      base = q0.size();
      frame(1, 5, 5);
      spr_ready = 1'b0;
      send(0, 77, 88, 1, 0, w);
      n = 0;
      while (!v0 && n < 4) begin tick(); n++; end
      check("ar_pre_valid", v0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_async_clear", {v0, x0, y0, c0, rdy0, iss0}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      proc_valid = 1'b1; proc_x = 9'd3; proc_y = 10'd3; proc_frame = 3'd1;
      spr_ready = 1'b1;
      repeat (5) tick();
      check("ar_ignore_ready", rdy0, 0);
      check("ar_ignore_valid", v0, 0);
      check("ar_no_beats", q0.size() - base, 0);
      check("ar_state", dut.state, WAIT_FRAME);
      proc_valid = 1'b0;

      // cursor disabled, single sprite
      base = q0.size();
      cb0 = cur_cnt;
      frame(0, 9, 9);
      send(0, 3, 4, 2, 1, w);
      wait_done(0, "nc_done");
      check("nc_beats", q0.size() - base, 1);
      check("nc_b0", q0[base], bt(3, 4, 2, 0));
      check("nc_issue", iss0, 1);
      check("nc_no_cursor", cur_cnt - cb0, 0);
      check("final_hold", hold_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Per-frame sequencer between the sprite processor and the graphics sprite port. The sprite processor is the game-sprite requester; the mouse cursor is the second requester.
- Buffers processor sprite requests and issues them to graphics over a valid/ready handshake, in arrival order.
- Appends one cursor sprite last in each frame, so the cursor draws on top.
- Bounds the per-frame sprite count and aborts cleanly if a new frame starts before the list is drained.

Parameters:
- CANVAS_WIDTH, 360, canvas width in pixels; X_W = $clog2(CANVAS_WIDTH).
- CANVAS_HEIGHT, 720, canvas height in pixels; Y_W = $clog2(CANVAS_HEIGHT).
- NUM_FRAMES, 5, sprite animation frames; F_W = $clog2(NUM_FRAMES).
- MAX_SPRITES, 64, maximum processor sprites accepted per frame.
- FIFO_DEPTH, 8, request buffer depth; must be a power of 2.
- CURSOR_FRAME, 0, frame number driven for the cursor sprite.

Ports:
- clk_pixel_in  in  1  pixel clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- new_frame_in  in  1  single-cycle pulse from video_sig_gen at the start of each frame.
- proc_valid_in  in  1  processor sprite request valid.
- proc_ready_out  out  1  scheduler accepts a processor request.
- proc_x_in  in  X_W  processor sprite x.
- proc_y_in  in  Y_W  processor sprite y.
- proc_frame_in  in  F_W  processor sprite animation frame.
- proc_last_in  in  1  marks the final sprite of this frame; qualified by the handshake.
- cursor_en_in  in  1  draw the cursor this frame.
- cursor_x_in  in  X_W  mouse x.
- cursor_y_in  in  Y_W  mouse y.
- spr_valid_out  out  1  sprite presented to graphics.
- spr_ready_in  in  1  graphics accepts the sprite.
- spr_x_out  out  X_W  sprite x to graphics.
- spr_y_out  out  Y_W  sprite y to graphics.
- spr_frame_out  out  F_W  sprite frame number to graphics.
- spr_is_cursor_out  out  1  current beat is the cursor.
- overrun_out  out  1  one-cycle pulse when a frame is aborted.
- drop_count_out  out  8  processor sprites dropped this frame; saturates at 255.
- issue_count_out  out  $clog2(MAX_SPRITES+2)  sprites issued to graphics this frame, cursor included.

Behaviour:
- Reset (rst_n_in=0, asynchronous): all outputs 0, FIFO empty, counters 0, state WAIT_FRAME.
- States: WAIT_FRAME, GAME, CURSOR, DONE.
- Frame start: on new_frame_in in any state, latch cursor_x_in, cursor_y_in, cursor_en_in; clear the counters and seen_last; next state GAME.
- Overrun: new_frame_in while in GAME or CURSOR, with FIFO non-empty, output valid, or the cursor not yet issued.
  - Flush the FIFO and deassert spr_valid_out next cycle, even without a handshake; this is the only permitted mid-beat withdrawal.
  - Pulse overrun_out for 1 cycle, then run the normal frame start.
- WAIT_FRAME and DONE: proc_ready_out=0, spr_valid_out=0; wait for new_frame_in.
- GAME, input side:
  - proc_ready_out = !fifo_full && !seen_last.
  - Accepted beat with accepted_count < MAX_SPRITES: push {x,y,frame} and increment accepted_count.
  - Accepted beat beyond MAX_SPRITES: discard and increment drop_count_out (saturating). proc_ready_out stays 1 so the processor never deadlocks.
  - proc_last_in on an accepted beat sets seen_last; that beat is itself a sprite.
- GAME, output side:
  - One registered output stage loads from the FIFO head whenever it is empty or its beat handshakes.
  - Minimum latency: accept at cycle t gives spr_valid_out at t+2. A first-word-fall-through FIFO with an output register is acceptable if it gives t+1; the bench checks ≤2.
  - While spr_valid_out && !spr_ready_in, all spr_* outputs are held stable.
  - Each output handshake increments issue_count_out.
- GAME exit: seen_last && FIFO empty && output stage empty → CURSOR if the latched cursor_en is 1, else DONE.
- CURSOR:
  - Present the latched cursor x/y with spr_frame_out=CURSOR_FRAME and spr_is_cursor_out=1.
  - On handshake → DONE.
  - The cursor is not counted against MAX_SPRITES.
- Simultaneous events: a push and pop in the same cycle on a full FIFO is allowed; ready is computed from the pre-pop full flag.
- Counters hold through DONE.
- Coordinates are passed through unmodified; no clamping.

Decomposition:
- Package sprite_pkg:
  - localparams X_W, Y_W, F_W derived from the canvas and frame parameters.
  - typedef sprite_t packed struct {x, y, frame}.
  - typedef enum sched_state_t {WAIT_FRAME, GAME, CURSOR, DONE}.
- Sub-module sprite_fifo: synchronous FIFO of sprite_t, parameter DEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - Same clock and reset as the parent.

Test Plan:
- Nominal frame: reset, new_frame, cursor_en=1 at (100,200), sprites (10,5,1), (20,6,2), (30,7,3) with last on the third, spr_ready=1 → four beats in order, the fourth being (100,200,0) with is_cursor=1; issue_count=4; state DONE; proc_ready=0.
- Backpressure: spr_ready=0 for 12 cycles while 10 sprites are offered → spr_* held constant; proc_ready drops after 8 FIFO entries (9 held with the output stage). Releasing ready drains all 10 in order.
- Budget: MAX_SPRITES=4, 6 sprites offered → 4 issued plus cursor; drop_count=2; issue_count=5; proc_ready never stalls.
- Overrun: new_frame after 3 queued, before last → overrun_out=1 for exactly 1 cycle; spr_valid=0 next cycle; FIFO empty; the new cursor position is latched.
- Async reset mid-beat with spr_valid=1 → outputs 0 immediately, without waiting for a clock edge. After release, proc_valid is ignored until new_frame.
- cursor_en=0 with 1 sprite flagged last → one beat only, is_cursor never asserted, issue_count=1.
